keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving one row low at a time and reading the column lines, which are pulled up and active-low.
- Debounces the scan result, emits one hex key code per physical press, and keeps the last four codes in a 16-bit word that can drive the 7-segment display's `dat` input directly.
- Forms the input-side counterpart of the display multiplexer.
- Shares that block's `ce1ms` strobe as its scan timebase.

---
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner interface: matrix lines plus decoded key outputs.
interface keypad_scanner_if;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] dat;

  modport master (input col, output row, key_code, key_valid, key_held, dat);
  modport slave  (output col, input row, key_code, key_valid, key_held, dat);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, per-scan key
// resolution, press/release debounce and a 4-nibble key history.
module keypad_scanner #(
  parameter int DEB_SCANS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  localparam logic [3:0] DEB = 4'(DEB_SCANS);

  logic [3:0]  col_meta_q, col_meta_d, col_s_q, col_s_d;
  logic [1:0]  row_cnt_q, row_cnt_d;
  logic [3:0]  row_q, row_d;
  logic [1:0]  hits_q, hits_d;        // keys seen this scan: 0, 1, 2 = many
  logic [3:0]  acc_code_q, acc_code_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;
  logic [15:0] dat_q, dat_d;

  logic [2:0]  nz;
  logic [1:0]  col_idx, row_hits;
  logic [2:0]  tot;
  logic [3:0]  code_now, scan_code;
  logic        scan_close, scan_key;

  // Next-state: sync, row scan accumulation, scan result and debounce FSM
  always_comb begin
    col_meta_d  = kp.col;
    col_s_d     = col_meta_q;
    row_cnt_d   = row_cnt_q;
    hits_d      = hits_q;
    acc_code_d  = acc_code_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    dat_d       = dat_q;
    key_valid_d = 1'b0;

    nz      = '0;
    col_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) col_idx = 2'(i);
      nz = nz + {2'b00, ~col_s_q[i]};
    end
    row_hits = (nz == 3'd0) ? 2'd0 : (nz == 3'd1) ? 2'd1 : 2'd2;
    tot      = {1'b0, hits_q} + {1'b0, row_hits};
    code_now = {row_cnt_q, col_idx};

    scan_close = 1'b0;
    scan_key   = 1'b0;
    scan_code  = acc_code_q;

    if (ce1ms) begin
      row_cnt_d = row_cnt_q + 2'd1;
      if (row_hits == 2'd1) acc_code_d = code_now;
      hits_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
      if (row_cnt_q == 2'd3) begin
        // Exactly one key over the whole scan; multi-key/ghosting reads as none
        scan_close = 1'b1;
        scan_key   = (tot == 3'd1);
        scan_code  = (row_hits == 2'd1) ? code_now : acc_code_q;
        hits_d     = '0;
        acc_code_d = '0;
      end
    end

    row_d = ~(4'b0001 << row_cnt_d);

    if (scan_close) begin
      case (state_q)
        IDLE: begin
          if (scan_key) begin
            cand_d = scan_code;
            cnt_d  = 4'd1;
            if (DEB_SCANS == 1) begin
              key_code_d  = scan_code;
              dat_d       = {dat_q[11:0], scan_code};
              key_valid_d = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (scan_key && scan_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) begin
              key_code_d  = cand_q;
              dat_d       = {dat_q[11:0], cand_q};
              key_valid_d = 1'b1;
              state_d     = HELD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (!scan_key) begin
            cnt_d   = 4'd1;
            state_d = (DEB_SCANS == 1) ? IDLE : RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (!scan_key) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    key_held_d = (state_d == HELD) || (state_d == RELEASE_CHK);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q  <= 4'b1111;
      col_s_q     <= 4'b1111;
      row_cnt_q   <= '0;
      row_q       <= 4'b1110;
      hits_q      <= '0;
      acc_code_q  <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      dat_q       <= '0;
    end else begin
      col_meta_q  <= col_meta_d;
      col_s_q     <= col_s_d;
      row_cnt_q   <= row_cnt_d;
      row_q       <= row_d;
      hits_q      <= hits_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      dat_q       <= dat_d;
    end
  end

  assign kp.row       = row_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.dat       = dat_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driving two DUTs
// (DEB_SCANS = 3 and 1) scan by scan against a debounce reference model.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce1ms = 1'b0;
  logic [15:0] pressed = '0;   // bit r*4+c = key (r,c) held down

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner_if if3 ();
  keypad_scanner_if if1 ();

  keypad_scanner #(.DEB_SCANS(3)) dut3 (.clk(clk), .rst(rst), .ce1ms(ce1ms), .kp(if3.master));
  keypad_scanner #(.DEB_SCANS(1)) dut1 (.clk(clk), .rst(rst), .ce1ms(ce1ms), .kp(if1.master));

  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its column to its row when that row is driven low
  function automatic logic [3:0] col_model(input logic [3:0] r, input logic [15:0] p);
    logic [3:0] c;
    c = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!r[rr] && p[rr*4+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign if3.col = col_model(if3.row, pressed);
  assign if1.col = col_model(if1.row, pressed);

  logic        kv [2];
  logic        kh [2];
  logic [3:0]  kc [2];
  logic [15:0] kd [2];
  assign kv[0] = if3.key_valid; assign kv[1] = if1.key_valid;
  assign kh[0] = if3.key_held;  assign kh[1] = if1.key_held;
  assign kc[0] = if3.key_code;  assign kc[1] = if1.key_code;
  assign kd[0] = if3.dat;       assign kd[1] = if1.dat;

  // Reference model state per instance
  int          deb [2] = '{3, 1};
  int          m_run [2];
  int          m_rel [2];
  logic [3:0]  m_cand [2];
  bit          m_held [2];
  bit          m_valid [2];
  logic [3:0]  m_code [2];
  logic [15:0] m_dat [2];
  int          obs_valid [2];   // total key_valid pulses seen

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_rel[k] = 0; m_cand[k] = '0; m_held[k] = 0;
      m_valid[k] = 0; m_code[k] = '0; m_dat[k] = '0;
    end
  endtask

  // One completed scan: press needs deb matching scans of the same key
  // (a different key while confirming costs the run), release needs deb empty scans.
  task automatic model_scan(input int k, input bit is_key, input logic [3:0] code);
    m_valid[k] = 0;
    if (!m_held[k]) begin
      if (!is_key) m_run[k] = 0;
      else if (m_run[k] == 0) begin m_cand[k] = code; m_run[k] = 1; end
      else if (code == m_cand[k]) m_run[k]++;
      else m_run[k] = 0;
      if (m_run[k] == deb[k]) begin
        m_held[k] = 1; m_valid[k] = 1; m_code[k] = m_cand[k];
        m_dat[k] = {m_dat[k][11:0], m_cand[k]}; m_rel[k] = 0; m_run[k] = 0;
      end
    end else begin
      if (is_key) m_rel[k] = 0; else m_rel[k]++;
      if (m_rel[k] == deb[k]) begin m_held[k] = 0; m_run[k] = 0; end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; ce1ms = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  // Run one full scan (4 strobes, 8 clk apart), then check both DUTs
  task automatic do_scan();
    int vc [2];
    int ones;
    logic [3:0] code;
    vc[0] = 0; vc[1] = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) vc[k] += int'(kv[k]);
      ce1ms = (i % 8 == 7);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) vc[k] += int'(kv[k]);
    ce1ms = 1'b0;
    ones = $countones(pressed);
    code = '0;
    for (int b = 0; b < 16; b++) if (pressed[b]) code = 4'(b);
    for (int k = 0; k < 2; k++) begin
      model_scan(k, ones == 1, code);
      obs_valid[k] += vc[k];
      n_checks++;
      if (vc[k] !== int'(m_valid[k])) begin
        n_fail++; $display("FAIL scan_valid[deb=%0d]: got %0d pulses want %0d", deb[k], vc[k], m_valid[k]);
      end
      n_checks++;
      if (kh[k] !== m_held[k]) begin
        n_fail++; $display("FAIL scan_held[deb=%0d]: got %b want %b", deb[k], kh[k], m_held[k]);
      end
      n_checks++;
      if (kd[k] !== m_dat[k]) begin
        n_fail++; $display("FAIL scan_dat[deb=%0d]: got %h want %h", deb[k], kd[k], m_dat[k]);
      end
      n_checks++;
      if (kc[k] !== m_code[k]) begin
        n_fail++; $display("FAIL scan_code[deb=%0d]: got %h want %h", deb[k], kc[k], m_code[k]);
      end
    end
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n; i++) do_scan();
  endtask

  task automatic test_reset();
    pressed = '0;
    apply_reset();
    n_checks++;
    if (if3.row !== 4'b1110 || if3.key_valid !== 1'b0 || if3.key_held !== 1'b0 ||
        if3.key_code !== 4'h0 || if3.dat !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got row=%b v=%b h=%b code=%h dat=%h want 1110 0 0 0 0000",
               if3.row, if3.key_valid, if3.key_held, if3.key_code, if3.dat);
    end
    n_checks++;
    if (if1.row !== 4'b1110 || if1.dat !== 16'h0000 || if1.key_held !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs_deb1: got row=%b dat=%h h=%b", if1.row, if1.dat, if1.key_held);
    end
  endtask

  task automatic test_single_press();
    int v0;
    apply_reset(); v0 = obs_valid[0];
    pressed = 16'h1 << 9;        // key (2,1)
    scans(6);
    pressed = '0;
    scans(2);
    n_checks++;
    if (if3.key_held !== 1'b1) begin
      n_fail++; $display("FAIL single_held_after2: got %b want 1", if3.key_held);
    end
    scans(1);
    n_checks++;
    if (if3.key_held !== 1'b0) begin
      n_fail++; $display("FAIL single_held_after3: got %b want 0", if3.key_held);
    end
    n_checks++;
    if (obs_valid[0] - v0 !== 1 || if3.key_code !== 4'd9 || if3.dat !== 16'h0009) begin
      n_fail++; $display("FAIL single_press: got pulses=%0d code=%h dat=%h want 1 9 0009",
                         obs_valid[0] - v0, if3.key_code, if3.dat);
    end
  endtask

  task automatic test_bounce();
    int v0;
    apply_reset(); v0 = obs_valid[0];
    pressed = 16'h1 << 3;        // key (0,3)
    scans(2);
    pressed = '0;
    scans(1);
    pressed = 16'h1 << 3;
    scans(2);
    pressed = '0;
    scans(3);
    n_checks++;
    if (obs_valid[0] - v0 !== 0 || if3.dat !== 16'h0000) begin
      n_fail++; $display("FAIL bounce: got pulses=%0d dat=%h want 0 0000", obs_valid[0] - v0, if3.dat);
    end
  endtask

  task automatic test_multi_key();
    int v0;
    apply_reset(); v0 = obs_valid[0];
    pressed = (16'h1 << 4) | (16'h1 << 14);   // (1,0) + (3,2)
    scans(10);
    n_checks++;
    if (obs_valid[0] - v0 !== 0) begin
      n_fail++; $display("FAIL multi_key_reject: got pulses=%0d want 0", obs_valid[0] - v0);
    end
    pressed = 16'h1 << 4;
    scans(3);
    n_checks++;
    if (obs_valid[0] - v0 !== 1 || if3.key_code !== 4'd4) begin
      n_fail++; $display("FAIL multi_key_release: got pulses=%0d code=%h want 1 4", obs_valid[0] - v0, if3.key_code);
    end
    pressed = '0;
    scans(3);
  endtask

  task automatic test_back_to_back();
    int v0;
    apply_reset(); v0 = obs_valid[0];
    pressed = 16'h1 << 9;
    scans(20);
    pressed = '0;
    scans(4);
    pressed = 16'h1 << 5;        // key (1,1)
    scans(4);
    pressed = '0;
    scans(3);
    n_checks++;
    if (obs_valid[0] - v0 !== 2 || if3.dat !== 16'h0095) begin
      n_fail++; $display("FAIL held_sequence: got pulses=%0d dat=%h want 2 0095", obs_valid[0] - v0, if3.dat);
    end
    for (int c = 1; c <= 5; c++) begin
      pressed = 16'h1 << c;
      scans(3);
      pressed = '0;
      scans(3);
    end
    n_checks++;
    if (if3.dat !== 16'h2345) begin
      n_fail++; $display("FAIL five_press_wrap: got dat=%h want 2345", if3.dat);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    apply_reset();
    pressed = 16'h1 << 6;        // key (1,2)
    scans(2);
    v0 = obs_valid[0];
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    n_checks++;
    if (if3.row !== 4'b1110 || if3.key_valid !== 1'b0 || if3.key_held !== 1'b0 ||
        if3.dat !== 16'h0000 || if3.key_code !== 4'h0) begin
      n_fail++; $display("FAIL reset_mid: got row=%b v=%b h=%b dat=%h code=%h want 1110 0 0 0000 0",
                         if3.row, if3.key_valid, if3.key_held, if3.dat, if3.key_code);
    end
    scans(2);
    n_checks++;
    if (obs_valid[0] - v0 !== 0) begin
      n_fail++; $display("FAIL reset_mid_partial: got pulses=%0d want 0", obs_valid[0] - v0);
    end
    scans(1);
    n_checks++;
    if (obs_valid[0] - v0 !== 1 || if3.dat !== 16'h0006) begin
      n_fail++; $display("FAIL reset_mid_accept: got pulses=%0d dat=%h want 1 0006", obs_valid[0] - v0, if3.dat);
    end
    pressed = '0;
    scans(3);
  endtask

  task automatic test_deb1();
    int v0;
    apply_reset(); v0 = obs_valid[1];
    pressed = 16'h1 << 15;       // key (3,3)
    scans(1);
    n_checks++;
    if (obs_valid[1] - v0 !== 1 || if1.key_code !== 4'hF || if1.dat !== 16'h000F) begin
      n_fail++; $display("FAIL deb1_single: got pulses=%0d code=%h dat=%h want 1 f 000f",
                         obs_valid[1] - v0, if1.key_code, if1.dat);
    end
    pressed = '0;
    scans(1);
    n_checks++;
    if (if1.key_held !== 1'b0) begin
      n_fail++; $display("FAIL deb1_release: got held=%b want 0", if1.key_held);
    end
  endtask

  task automatic test_random();
    int sel, hold;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) pressed = '0;
      else if (sel < 8) pressed = 16'h1 << $urandom_range(0, 15);
      else pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      hold = $urandom_range(1, 5);
      scans(hold);
    end
    pressed = '0;
    scans(3);
  endtask

  initial begin
    obs_valid[0] = 0; obs_valid[1] = 0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_back_to_back();
    test_reset_mid();
    test_deb1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
